// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter.
//   arb_state_t   : arbiter FSM states
//   owner_t       : requester ids (CPU = 0, DBG = 1)
//   TIMEOUT_DEF   : default watchdog limit in WAIT cycles
//   TIMEOUT_RDATA : read data returned on a watchdog-forced completion
//   cnt_width()   : width of a counter that must hold 0..timeout
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } owner_t;

  localparam int TIMEOUT_DEF = 255;

  // Wide enough for any DW up to 64; users slice the low DW bits.
  localparam logic [63:0] TIMEOUT_RDATA = '1;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sram_arb_port.sv
// One requester port of the SRAM access arbiter: captures a request pulse
// into a latch, holds busy until the arbiter reports completion, and
// registers the returned read data and the completion pulse.
//   s_clk, s_rst       : clock, synchronous active-high reset
//   wr_req, rd_req     : request pulses (write wins when both are high)
//   addr, wdata        : sampled when a request is accepted
//   done, done_rdata   : completion strobe and read data from the arbiter
//   busy               : request pending or in flight
//   lat_addr/wdata     : latched request for the arbiter mux
//   lat_is_read        : latched operation type
//   rdata, valid       : read data (held) and one-cycle completion pulse
module sram_arb_port #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          s_clk,
  input  logic          s_rst,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          done,
  input  logic [DW-1:0] done_rdata,
  output logic          busy,
  output logic [AW-1:0] lat_addr,
  output logic [DW-1:0] lat_wdata,
  output logic          lat_is_read,
  output logic [DW-1:0] rdata,
  output logic          valid
);

  logic accept;

  // A pulse arriving while busy is dropped without touching the latch.
  assign accept = (wr_req | rd_req) & ~busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  // NOTE: the request latch is a handful of flops, not a memory, so it is
  // reset along with the control bits to keep outputs deterministic.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      busy        <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_is_read <= 1'b0;
      rdata       <= '0;
      valid       <= 1'b0;
    end else begin
      valid <= done;
      // done only arrives while busy, and accept only while idle, so the
      // two branches never compete.
      if (done) begin
        busy <= 1'b0;
        if (lat_is_read) rdata <= done_rdata;
      end else if (accept) begin
        busy        <= 1'b1;
        lat_addr    <= addr;
        lat_wdata   <= wdata;
        lat_is_read <= ~wr_req;
      end
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the single SRAM controller port between the CPU bus (c_*) and the
// UART debug bridge (d_*). One operation runs at a time; the debug lock
// level blocks new CPU grants; a watchdog forces completion when the SRAM
// controller never answers.
//   s_clk, s_rst         : clock, synchronous active-high reset
//   c_* / d_*            : requester ports (request pulses, address, write
//                          data in; read data, valid pulse, busy out)
//   d_lock               : debug exclusive-access level (s_clk synchronous)
//   m_*                  : SRAM controller port
//   lock_active          : registered d_lock
//   m_timeout            : pulse on a watchdog-forced completion
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          s_clk,
  input  logic          s_rst,
  input  logic          c_wr_req,
  input  logic          c_rd_req,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_valid,
  output logic          c_busy,
  input  logic          d_lock,
  input  logic          d_wr_req,
  input  logic          d_rd_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_busy,
  output logic          m_wr_req,
  output logic          m_rd_req,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_valid,
  output logic          lock_active,
  output logic          m_timeout
);

  localparam int CW = cnt_width(TIMEOUT);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, last_grant_q, grant;
  logic [CW-1:0] wd_cnt_q;

  logic [AW-1:0] c_lat_addr,  d_lat_addr,  sel_addr;
  logic [DW-1:0] c_lat_wdata, d_lat_wdata, sel_wdata;
  logic          c_lat_is_read, d_lat_is_read, sel_is_read;

  logic          cpu_elig, dbg_elig, any_elig, wd_expire;
  logic          issue, done, forced, c_done, d_done;
  logic [DW-1:0] done_rdata;

  sram_arb_port #(.AW(AW), .DW(DW)) u_cpu_port (
    .s_clk       (s_clk),
    .s_rst       (s_rst),
    .wr_req      (c_wr_req),
    .rd_req      (c_rd_req),
    .addr        (c_addr),
    .wdata       (c_wdata),
    .done        (c_done),
    .done_rdata  (done_rdata),
    .busy        (c_busy),
    .lat_addr    (c_lat_addr),
    .lat_wdata   (c_lat_wdata),
    .lat_is_read (c_lat_is_read),
    .rdata       (c_rdata),
    .valid       (c_valid)
  );

  sram_arb_port #(.AW(AW), .DW(DW)) u_dbg_port (
    .s_clk       (s_clk),
    .s_rst       (s_rst),
    .wr_req      (d_wr_req),
    .rd_req      (d_rd_req),
    .addr        (d_addr),
    .wdata       (d_wdata),
    .done        (d_done),
    .done_rdata  (done_rdata),
    .busy        (d_busy),
    .lat_addr    (d_lat_addr),
    .lat_wdata   (d_lat_wdata),
    .lat_is_read (d_lat_is_read),
    .rdata       (d_rdata),
    .valid       (d_valid)
  );

  // Eligibility and round-robin choice. The lock only gates new CPU grants;
  // an op already in flight is never aborted.
  assign cpu_elig  = c_busy & ~lock_active;
  assign dbg_elig  = d_busy;
  assign any_elig  = cpu_elig | dbg_elig;
  assign grant     = (dbg_elig && (!cpu_elig || last_grant_q == CPU)) ? DBG : CPU;
  assign wd_expire = (wd_cnt_q == CW'(TIMEOUT - 1));

  assign sel_addr    = (grant == DBG) ? d_lat_addr    : c_lat_addr;
  assign sel_wdata   = (grant == DBG) ? d_lat_wdata   : c_lat_wdata;
  assign sel_is_read = (grant == DBG) ? d_lat_is_read : c_lat_is_read;

  // State register.
  always_ff @(posedge s_clk) begin
    if (s_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_elig) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (m_valid || wd_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. m_valid outside WAIT is a stray and is ignored here.
  always_comb begin
    issue  = (state_q == IDLE) && any_elig;
    done   = (state_q == WAIT) && (m_valid || wd_expire);
    forced = (state_q == WAIT) && !m_valid && wd_expire;
    c_done = done && (owner_q == CPU);
    d_done = done && (owner_q == DBG);
    done_rdata = forced ? TIMEOUT_RDATA[DW-1:0] : m_rdata;
  end

  // Datapath, SRAM request pulses, watchdog and lock register.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      last_grant_q <= DBG;
      owner_q      <= CPU;
      m_wr_req     <= 1'b0;
      m_rd_req     <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      wd_cnt_q     <= '0;
      m_timeout    <= 1'b0;
      lock_active  <= 1'b0;
    end else begin
      lock_active <= d_lock;
      m_timeout   <= forced;
      // Request pulses rise on grant and fall after the single ISSUE cycle.
      m_wr_req    <= issue & ~sel_is_read;
      m_rd_req    <= issue &  sel_is_read;
      if (issue) begin
        last_grant_q <= grant;
        owner_q      <= grant;
        m_addr       <= sel_addr;
        m_wdata      <= sel_wdata;
      end
      if (state_q == ISSUE)              wd_cnt_q <= '0;
      else if (state_q == WAIT && !done) wd_cnt_q <= wd_cnt_q + CW'(1);
    end
  end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Fast-domain (s_clk) arbiter that shares the single SRAM controller port between two requesters: the CPU bus interface (c_) and the UART debug CDC bridge (d_). It captures pulse requests, runs one SRAM operation at a time, and routes each completion back to its owner. The debug lock level (the bridge's s_req) gives the debug port exclusive access. A watchdog prevents a missing completion from hanging the bus.

Parameters:
AW, 16, address width
DW, 16, data width
TIMEOUT, 255, max cycles in WAIT before forced completion (>=2)

Ports:
s_clk  in  1  clock
s_rst  in  1  synchronous reset, active-high
c_wr_req  in  1  CPU write request pulse
c_rd_req  in  1  CPU read request pulse
c_addr  in  AW  CPU address, sampled with the request
c_wdata  in  DW  CPU write data, sampled with the request
c_rdata  out  DW  CPU read data, held until the next CPU read completes
c_valid  out  1  CPU completion pulse
c_busy  out  1  CPU request pending or in flight
d_lock  in  1  debug exclusive-access level, already synchronized to s_clk
d_wr_req  in  1  debug write request pulse
d_rd_req  in  1  debug read request pulse
d_addr  in  AW  debug address
d_wdata  in  DW  debug write data
d_rdata  out  DW  debug read data
d_valid  out  1  debug completion pulse
d_busy  out  1  debug request pending or in flight
m_wr_req  out  1  SRAM write pulse
m_rd_req  out  1  SRAM read pulse
m_addr  out  AW  SRAM address
m_wdata  out  DW  SRAM write data
m_rdata  in  DW  SRAM read data, qualified by m_valid
m_valid  in  1  SRAM completion pulse, for reads and writes
lock_active  out  1  registered d_lock
m_timeout  out  1  pulse on watchdog-forced completion

Behaviour:
- Clocking and reset: one clock, s_clk. Reset is synchronous and active-high (s_rst). Every output resets to 0, state resets to IDLE, pending flags clear, and last_grant resets to DBG.
- Request capture, per port:
  - A request is accepted when wr_req|rd_req is high and busy=0.
  - On acceptance, latch addr, wdata and is_read, and set pend. busy goes high at the next edge.
  - If wr_req and rd_req are high in the same cycle, the write wins.
  - A request pulse while busy=1 is ignored, with no side effects.
- lock_active <= d_lock every cycle.
- CPU eligibility: CPU is eligible only when pend=1 and lock_active=0.
- Debug eligibility: debug is eligible whenever pend=1.
- IDLE state:
  - If no port is eligible, stay in IDLE.
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port that is not last_grant (round-robin).
  - On grant: update last_grant, load m_addr/m_wdata from the owner's latch, assert m_wr_req or m_rd_req (registered), and go to ISSUE.
- ISSUE state (1 cycle): request pulse is visible. Drop m_*_req, clear the watchdog counter, go to WAIT. m_addr/m_wdata stay stable until completion.
- WAIT state:
  - On m_valid: for a read, owner rdata <= m_rdata. Pulse owner valid for 1 cycle, clear owner pend/busy at the same edge, go to IDLE.
  - Otherwise increment the counter. When counter = TIMEOUT-1, force completion: read data = all ones, owner valid pulse, m_timeout pulse, go to IDLE.
- Latency: request sampled in cycle N -> m_*_req high in cycle N+2 (if granted immediately). m_valid in cycle K -> owner valid, busy=0 and rdata updated in cycle K+1.
- Write completions leave rdata unchanged. rdata is never cleared except by reset.
- m_valid in IDLE or ISSUE is ignored (stray).
- Lock transitions:
  - d_lock rising while a CPU op is in flight does not abort it.
  - Subsequent CPU pends wait until lock_active falls.
  - Debug requests are accepted whether or not lock is held.
- Reset mid-operation: the op is abandoned and no completion is reported. The SRAM controller shares s_rst.
- A requester may re-request in the cycle after its valid pulse (busy is already low).

Decomposition:
- Package sram_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT}
  - owner ids CPU=0, DBG=1
  - TIMEOUT default
  - timeout read pattern (all ones)
  - counter width function clog2(TIMEOUT+1)
- Sub-module sram_arb_port: request latch, pend/busy, rdata/valid register. Instantiated twice (CPU and debug).
- Top level holds the FSM, round-robin pointer, watchdog and mux.

Test Plan:
- CPU read 0x1234, m_valid 5 cycles after m_rd_req with m_rdata 0xBEEF -> m_rd_req high exactly 1 cycle with m_addr 0x1234; one cycle after m_valid, c_valid pulses, c_rdata=0xBEEF, c_busy=0; d_valid stays 0.
- First tie after reset: CPU write 0x0010/0xAAAA and debug read 0x0020 in the same cycle -> CPU write issued first; debug read issued only after CPU completion.
- Second tie: both ports request again simultaneously -> debug granted first.
- d_lock=1, then CPU read 0x0040 -> no m_rd_req for 100 cycles and c_busy stays 1; debug write 0x0050 completes normally; after d_lock falls, m_rd_req for 0x0040 appears within 3 cycles.
- TIMEOUT=16, debug read with m_valid never asserted -> d_valid pulse 16 cycles into WAIT with d_rdata=0xFFFF, m_timeout pulse, next CPU request serviced normally.
- Busy/reset: second c_wr_req while CPU busy -> only one m_wr_req observed. s_rst asserted during WAIT -> outputs 0 at the next edge, and a subsequent stray m_valid produces no c_valid/d_valid.
